// File: rtl/w0rm_alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode type and
// result flag bit positions used by the ALU function units.
package w0rm_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND    = 4'h0,
    OP_OR     = 4'h1,
    OP_XOR    = 4'h2,
    OP_NOT    = 4'h3,
    OP_NEG    = 4'h4,
    OP_NAND   = 4'h5,
    OP_NOR    = 4'h6,
    OP_XNOR   = 4'h7,
    OP_ANDN   = 4'h8,
    OP_POPCNT = 4'h9,
    OP_CLZ    = 4'hA,
    OP_CTZ    = 4'hB
  } opcode_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVER  = 2;
  localparam int FLAG_CARRY = 3;

endpackage

// File: rtl/w0rm_alu_logic_core.sv
// Combinational logic-ALU function unit: opcode/operands -> result, flags, illegal.
// Ports: opcode, data_a, data_b in; result, flags, illegal out. POPCNT/CLZ/CTZ only with W0RM_ALU_LOGIC_BITCOUNT_EN.
module w0rm_alu_logic_core
  import w0rm_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            flags,
  output logic                  illegal
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

`ifdef W0RM_ALU_LOGIC_BITCOUNT_EN
  logic [DATA_WIDTH-1:0] pop;
  logic [DATA_WIDTH-1:0] clz;
  logic [DATA_WIDTH-1:0] ctz;

  // Zero input leaves clz/ctz at DATA_WIDTH.
  always_comb begin
    pop = '0;
    clz = DATA_WIDTH'(DATA_WIDTH);
    ctz = DATA_WIDTH'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + DATA_WIDTH'(data_a[i]);
      if (data_a[i]) clz = DATA_WIDTH'(DATA_WIDTH - 1 - i);
    end
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (data_a[i]) ctz = DATA_WIDTH'(i);
    end
  end
`endif

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (opcode)
      OP_AND:    result = data_a & data_b;
      OP_OR:     result = data_a | data_b;
      OP_XOR:    result = data_a ^ data_b;
      OP_NOT:    result = ~data_a;
      OP_NEG:    result = -data_a;
      OP_NAND:   result = ~(data_a & data_b);
      OP_NOR:    result = ~(data_a | data_b);
      OP_XNOR:   result = ~(data_a ^ data_b);
      OP_ANDN:   result = data_a & ~data_b;
`ifdef W0RM_ALU_LOGIC_BITCOUNT_EN
      OP_POPCNT: result = pop;
      OP_CLZ:    result = clz;
      OP_CTZ:    result = ctz;
`endif
      default:   illegal = 1'b1;
    endcase
  end

  // OVER/CARRY mark the two NEG corner inputs.
  always_comb begin
    flags             = '0;
    flags[FLAG_ZERO]  = (result == '0);
    flags[FLAG_NEG]   = result[DATA_WIDTH-1];
    flags[FLAG_OVER]  = (opcode == OP_NEG) && (data_a == MOST_NEG);
    flags[FLAG_CARRY] = (opcode == OP_NEG) && (data_a == '0);
  end

endmodule

// File: rtl/w0rm_alu_logic_pipe.sv
// Pipelined logic ALU with valid/ready handshake and collapsing bubbles.
// Ports: clk, rst_n, in_valid/in_ready/opcode/data_a/data_b, out_valid/out_ready/result/result_flags/illegal_op. Macro: W0RM_ALU_LOGIC_BITCOUNT_EN.
module w0rm_alu_logic_pipe
  import w0rm_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            result_flags,
  output logic                  illegal_op
);

  localparam int LAST = PIPE_STAGES - 1;

  logic [DATA_WIDTH-1:0] core_res;
  logic [3:0]            core_flg;
  logic                  core_ill;

  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [PIPE_STAGES-1:0] ill_q, ill_d;
  logic [PIPE_STAGES-1:0] room;
  logic [DATA_WIDTH-1:0]  res_q [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  res_d [PIPE_STAGES];
  logic [3:0]             flg_q [PIPE_STAGES];
  logic [3:0]             flg_d [PIPE_STAGES];

  w0rm_alu_logic_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .opcode (opcode),
    .data_a (data_a),
    .data_b (data_b),
    .result (core_res),
    .flags  (core_flg),
    .illegal(core_ill)
  );

  // room[k]: stage k can take new content this cycle
  // (empty, or its occupant moves on).
  always_comb begin
    room       = '0;
    room[LAST] = !vld_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      room[k] = !vld_q[k] || room[k+1];
    end
  end

  assign in_ready = room[0];

  always_comb begin
    vld_d = vld_q;
    ill_d = ill_q;
    res_d = res_q;
    flg_d = flg_q;
    if (room[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        res_d[0] = core_res;
        flg_d[0] = core_flg;
        ill_d[0] = core_ill;
      end
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (room[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          res_d[k] = res_q[k-1];
          flg_d[k] = flg_q[k-1];
          ill_d[k] = ill_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ill_q <= '0;
      res_q <= '{default: '0};
      flg_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      ill_q <= ill_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign out_valid    = vld_q[LAST];
  assign result       = res_q[LAST];
  assign result_flags = flg_q[LAST];
  assign illegal_op   = ill_q[LAST];

endmodule
